// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH cycles; MTHI/MTLO complete in one cycle.
// Optional feature macro: MDU_ABORT_EN adds an 'abort' input that cancels an
// in-flight multiply/divide without touching HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;     // multiply: {partial sum, remaining multiplier}
  logic [WIDTH-1:0]   mcand_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;     // holds dividend magnitude, fills with quotient bits
  logic               neg_res_q;  // product / quotient needs negation
  logic               neg_rem_q;  // remainder takes the dividend's sign
  logic               div_zero_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               abort_w;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_d, quot_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MDU_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Operand conditioning: magnitudes and sign flags for signed ops.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & rs_data[WIDTH-1];
    b_neg     = signed_op & rt_data[WIDTH-1];
    a_mag     = a_neg ? (~rs_data + 1'b1) : rs_data;
    b_mag     = b_neg ? (~rt_data + 1'b1) : rt_data;
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d    = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift = {rem_q, quot_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, mcand_q});
    rem_d     = div_ok ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
    quot_d    = {quot_q[WIDTH-2:0], div_ok};
  end

  // Sign correction of the final step's result; a zero divisor forces an all-ones
  // quotient while the remainder path naturally reproduces the dividend.
  always_comb begin
    prod_fix = neg_res_q ? (~prod_d + 1'b1) : prod_d;
    quot_fix = div_zero_q ? '1 : (neg_res_q ? (~quot_d + 1'b1) : quot_d);
    rem_fix  = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
  end

  // Control FSM with registered busy/done and HI/LO update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mcand_q   <= a_mag;
                prod_q    <= {{WIDTH{1'b0}}, b_mag};
                neg_res_q <= a_neg ^ b_neg;
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                state_q   <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                mcand_q    <= b_mag;
                quot_q     <= a_mag;
                rem_q      <= '0;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (rt_data == '0);
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                state_q    <= S_DIV;
              end
              OP_MTHI: hi_q <= rs_data;
              OP_MTLO: lo_q <= rs_data;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              hi_q    <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q    <= prod_fix[WIDTH-1:0];
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_DIV: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              hi_q    <= rem_fix;
              lo_q    <= quot_fix;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {hi,lo},
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd7;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
`ifdef MDU_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
`ifdef MDU_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("done_result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clock);
    #1;
    start = 1'b0; op = 3'd7; rs_data = 32'hA5A5_A5A5; rt_data = 32'h5A5A_5A5A;
  endtask

  // Counts busy cycles up to the done pulse; then requires done to drop.
  task automatic wait_done(output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
      if (busy) nbusy++;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    @(negedge clock);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] expv);
    int n;
    exp_q.push_back(expv);
    issue(o, a, b);
    wait_done(n);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    check("reset_outputs", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;

    // MULTU max*max, with busy duration measured
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("multu_busy_cycles", 64'(n), 64'd32);

    run(3'd0, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1);
    run(3'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run(3'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    run(3'd2, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD);
    run(3'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run(3'd3, 32'd1000,      32'd3,        64'h0000_0001_0000_014D);
    run(3'd3, 32'd100,       32'd0,        64'h0000_0064_FFFF_FFFF);
    run(3'd2, 32'hFFFF_FFFB, 32'd0,        64'hFFFF_FFFB_FFFF_FFFF);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // MTHI/MTLO single-cycle writes
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi", {busy, done, hi}, {2'b00, 32'h1234_5678});
    issue(3'd5, 32'h0BAD_F00D, 32'd0);
    check("mtlo", {busy, done, lo}, {2'b00, 32'h0BAD_F00D});

    // op 6 is a no-op
    issue(3'd6, 32'h5555_5555, 32'h1);
    check("op6_noop", {busy, hi, lo}, {1'b0, 32'h1234_5678, 32'h0BAD_F00D});

    // starts while busy are ignored
    exp_q.push_back(64'h0000_0000_0000_000C);
    issue(3'd1, 32'd3, 32'd4);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(3'd3, 32'd99, 32'd7);
    check("ignored_while_busy", {busy, hi, lo}, {1'b1, 32'h1234_5678, 32'h0BAD_F00D});
    wait_done(n);

    // reset mid-operation
    issue(3'd4, 32'h0000_00AA, 32'd0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_mid_op", {busy, done, hi, lo}, 66'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("after_reset_idle", {63'd0, busy}, 64'd0);

`ifdef MDU_ABORT_EN
    issue(3'd4, 32'h0000_1111, 32'd0);
    issue(3'd5, 32'h0000_2222, 32'd0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check("abort", {busy, hi, lo}, {1'b0, 32'h0000_1111, 32'h0000_2222});
    repeat (40) @(negedge clock);
`endif

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage and is fed by the register-file read ports (rs data, rt data).
- Executes MULT, MULTU, DIV, DIVU in 32 cycles, one radix-2 step per cycle; MTHI and MTLO complete in a single cycle.
- HI/LO are read continuously by the writeback path for MFHI/MFLO; `busy` is the stall request to the PC/fetch logic.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled on the rising edge of clock.
- op  in  3  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7=no-op.
- rs_data  in  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source).
- rt_data  in  WIDTH  operand B (multiplier / divisor).
- busy  out  1  high while a multiply/divide is in progress.
- done  out  1  single-cycle pulse when HI/LO have been updated by a multiply/divide.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - busy=0, done=0, hi=0, lo=0.
  - Internal counter=0, state=IDLE.
  - Internal accumulators cleared.
- States:
  - IDLE -> MUL on start with op=0/1.
  - IDLE -> DIV on start with op=2/3.
  - MUL/DIV -> FIN when the counter reaches WIDTH-1.
  - FIN -> IDLE unconditionally.
- Accepting a start (edge E0, IDLE only):
  - Latch operand magnitudes. For signed ops take the absolute value; for unsigned ops pass the operand through.
  - Latch the sign flags.
  - Set counter=0 and busy=1 from E0.
- MUL step (shift-add):
  - Each cycle, conditionally add the multiplicand into the upper half of a 2*WIDTH product register.
  - Then shift the product register right by 1.
- DIV step (restoring):
  - Shift the {remainder, quotient} pair left by 1.
  - Trial-subtract the divisor.
  - Set the quotient bit to 1 if the result is non-negative, otherwise restore.
- Completion:
  - Edge E32 (WIDTH edges after E0) enters FIN.
  - HI/LO are written on that edge with sign correction applied.
  - busy=0 and done=1 for exactly one cycle from E32.
  - hi/lo values are valid when done=1.
- Signed sign correction:
  - Product: negate if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- MULT/MULTU results: hi=product[63:32], lo=product[31:0].
- DIV/DIVU results: lo=quotient, hi=remainder.
- Divide by zero:
  - Latency is unchanged (32 cycles).
  - Result: lo=all ones, hi=dividend (rs_data as presented, unmodified).
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (two's-complement wrap); no exception is raised.
- MTHI/MTLO:
  - In IDLE, start with op=4 writes hi=rs_data on that edge; op=5 writes lo=rs_data.
  - busy and done stay 0.
- start while busy=1: ignored, for every op including MTHI/MTLO. The in-flight operation is unaffected. The CPU must stall, so this is an illegal-use condition that the unit tolerates.
- start in FIN: ignored. A new start is accepted only once the unit has returned to IDLE.
- op=6/7 with start: no effect.
- Operands are captured at E0 only; rs_data and rt_data may change freely while busy.
- Reset mid-operation: immediately forces busy=0, done=0, hi=lo=0 and state=IDLE. No done pulse is produced.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit), used for branch-flush or exception.
  - abort=1 on an edge while busy returns the unit to IDLE on that edge, with no HI/LO update and no done pulse.
  - abort in IDLE has no effect.
  - abort has priority over completion on the same edge.
- Undefined: the port is absent and an operation always runs to completion.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high for 32 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=100, rt=0 -> done after 32 cycles with lo=0xFFFFFFFF, hi=0x00000064.
- MTHI rs=0x12345678, then during a later MULTU issue MTLO and a second start -> hi=0x12345678 after one edge with busy=0; the MTLO and second start issued while busy are ignored; MULTU completes with its own result.
- DIVU 1000/3 with reset asserted at cycle 10 -> busy=0, hi=lo=0 immediately, no done. With MDU_ABORT_EN, abort at cycle 10 instead -> hi/lo retain their prior values, no done.
